// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit RISC CPU control path: opcode encodings,
// the eight instruction-cycle phases, and a helper that classifies opcodes
// whose operand is fetched from memory and written into the accumulator.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef enum logic [2:0] {
    P_INST_ADDR  = 3'd0,
    P_INST_FETCH = 3'd1,
    P_INST_LOAD  = 3'd2,
    P_IDLE       = 3'd3,
    P_OP_ADDR    = 3'd4,
    P_OP_FETCH   = 3'd5,
    P_ALU_OP     = 3'd6,
    P_STORE      = 3'd7
  } phase_t;

  // True for instructions that read a memory operand into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      ADD, AND, XOR, LDA: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if
// Bundles the controller's instruction inputs (opcode, zero) with the
// datapath control strobes it produces.
//   master : controller side  (inputs opcode/zero, drives strobes)
//   slave  : datapath side    (drives opcode/zero, observes strobes)
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       halt;
  logic       inc_pc;
  logic       ld_ac;
  logic       ld_pc;
  logic       wr;
  logic       data_e;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );
endinterface

// File: rtl/cpu_controller_phase_counter.sv
// phase_counter
// Three-bit wrapping instruction-phase counter.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, returns to P_INST_ADDR
//   hold  : freezes the phase when high
//   phase : current instruction phase
module phase_counter
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  output phase_t phase
);

  // P7 wraps to P0 through natural 3-bit overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= P_INST_ADDR;
    else if (!hold)
      phase <= phase_t'(phase + 3'd1);
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller
// Eight-phase control sequencer for the 8-bit RISC CPU. Decodes the current
// phase, opcode and accumulator zero flag into datapath control strobes.
// A HLT instruction parks the sequencer at P_OP_ADDR until reset.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : opcode/zero in, sel/rd/ld_ir/halt/inc_pc/ld_ac/ld_pc/wr/data_e out
module cpu_controller
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  cpu_controller_if.master        bus
);

  phase_t phase;
  logic   halted;
  logic   halt_now;
  logic   hold;
  logic   aluop;

  // HLT is taken at the P_OP_ADDR edge; the same edge must also stop the
  // counter, otherwise the phase would slip to P_OP_FETCH before freezing.
  assign halt_now = !halted && (phase == P_OP_ADDR) && (bus.opcode == HLT);
  assign hold     = halted || halt_now;
  assign aluop    = is_aluop(bus.opcode);

  phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .phase (phase)
  );

  // Sticky halted flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (halt_now)
      halted <= 1'b1;
  end

  // Strobe decode. While halted, every strobe except halt is suppressed
  // regardless of phase or opcode.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    if (halted) begin
      bus.halt = 1'b1;
    end else begin
      case (phase)
        P_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        P_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        P_INST_LOAD, P_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        P_OP_ADDR: begin
          bus.inc_pc = (bus.opcode != HLT);
          bus.halt   = (bus.opcode == HLT);
        end
        P_OP_FETCH: begin
          bus.rd = aluop;
        end
        P_ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == JMP);
          bus.data_e = (bus.opcode == STO);
        end
        P_STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = (bus.opcode == JMP);
          bus.wr     = (bus.opcode == STO);
          bus.data_e = (bus.opcode == STO);
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
// Self-checking bench for cpu_controller. Strobe vectors are packed as
// {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] e;
    string      name;
  } sb_t;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [8:0] e4;
    logic [8:0] e5;
    logic [8:0] e6;
    logic [8:0] e7;
    string      name;
  } vec_t;

  sb_t        sb[$];
  int         total;
  int         bad;
  vec_t       vecs[9];
  logic [8:0] fetch_exp[4];

  localparam logic [8:0] E_RESET = 9'b100000000;
  localparam logic [8:0] E_HALT  = 9'b000100000;

  function automatic logic [8:0] outs();
    return {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
            bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
  endfunction

  // Drive the instruction inputs and record what the strobes must show.
  task automatic applyStimulus(input logic [2:0] op, input logic z,
                               input logic [8:0] e, input string name);
    bus.opcode = op;
    bus.zero   = z;
    sb.push_back('{e, name});
  endtask

  // Pop the oldest expectation and compare it with the live strobes.
  task automatic checkOutput();
    sb_t        item;
    logic [8:0] got;
    got = outs();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty got=%b", got);
    end else begin
      item = sb.pop_front();
      if (got !== item.e) begin
        bad++;
        $display("[TB] FAIL %s got=%b exp=%b", item.name, got, item.e);
      end
    end
  endtask

  // One phase: drive after the edge, check mid-cycle, advance to next edge.
  task automatic stepPhase(input logic [2:0] op, input logic z,
                           input logic [8:0] e, input string name);
    applyStimulus(op, z, e, name);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge, in phase P0.
  task automatic resetDut();
    rst = 1'b1;
    #2;
    applyStimulus(3'($urandom_range(0, 7)), 1'b0, E_RESET, "reset_assert");
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs P0..P3 with random opcodes, since they are don't-care there.
  task automatic fetchPhases(input string name);
    for (int p = 0; p < 4; p++)
      stepPhase(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                fetch_exp[p], name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.opcode  = HLT;
    bus.zero    = 1'b0;

    fetch_exp[0] = 9'b100000000;
    fetch_exp[1] = 9'b110000000;
    fetch_exp[2] = 9'b111000000;
    fetch_exp[3] = 9'b111000000;

    //               op   z     P4            P5            P6            P7
    vecs[0] = '{ADD, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000, "add"};
    vecs[1] = '{ADD, 1'b1, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000, "add_z"};
    vecs[2] = '{AND, 1'b1, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000, "and"};
    vecs[3] = '{XOR, 1'b0, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000, "xor"};
    vecs[4] = '{LDA, 1'b1, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000, "lda"};
    vecs[5] = '{STO, 1'b0, 9'b000010000, 9'b000000000, 9'b000000001, 9'b000000011, "sto"};
    vecs[6] = '{SKZ, 1'b1, 9'b000010000, 9'b000000000, 9'b000010000, 9'b000000000, "skz_z1"};
    vecs[7] = '{SKZ, 1'b0, 9'b000010000, 9'b000000000, 9'b000000000, 9'b000000000, "skz_z0"};
    vecs[8] = '{JMP, 1'b1, 9'b000010000, 9'b000000000, 9'b000000100, 9'b000000100, "jmp"};

    repeat (2) @(posedge clk);
    #1;
    resetDut();

    // Back-to-back instructions, exercising the P7 to P0 wrap.
    for (int v = 0; v < 9; v++) begin
      fetchPhases({vecs[v].name, "_fetch"});
      stepPhase(vecs[v].op, vecs[v].z, vecs[v].e4, {vecs[v].name, "_p4"});
      stepPhase(vecs[v].op, vecs[v].z, vecs[v].e5, {vecs[v].name, "_p5"});
      stepPhase(vecs[v].op, vecs[v].z, vecs[v].e6, {vecs[v].name, "_p6"});
      stepPhase(vecs[v].op, vecs[v].z, vecs[v].e7, {vecs[v].name, "_p7"});
    end

    // Asynchronous reset in the middle of P5 of an ADD.
    resetDut();
    fetchPhases("rst_mid_fetch");
    stepPhase(ADD, 1'b0, 9'b000010000, "rst_mid_p4");
    applyStimulus(ADD, 1'b0, 9'b010000000, "rst_mid_p5");
    #2;
    checkOutput();
    rst = 1'b1;
    #1;
    applyStimulus(ADD, 1'b0, E_RESET, "rst_mid_async");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(ADD, 1'b0, E_RESET, "rst_mid_released");
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus(ADD, 1'b0, 9'b110000000, "rst_mid_next_p1");
    checkOutput();

    // HLT: parks at P4, ignores later opcodes, leaves only through reset.
    resetDut();
    fetchPhases("hlt_fetch");
    stepPhase(HLT, 1'b0, E_HALT, "hlt_p4");
    for (int i = 0; i < 20; i++) begin
      stepPhase((i < 5) ? HLT : ADD, 1'($urandom_range(0, 1)), E_HALT, "halted");
      total++;
      if (dut.phase !== P_OP_ADDR) begin
        bad++;
        $display("[TB] FAIL halted_phase got=%0d exp=%0d", dut.phase, P_OP_ADDR);
      end
    end
    rst = 1'b1;
    #1;
    applyStimulus(ADD, 1'b0, E_RESET, "hlt_reset");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(ADD, 1'b0, E_RESET, "hlt_reset_p0");
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus(ADD, 1'b0, 9'b110000000, "hlt_reset_p1");
    checkOutput();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-phase control sequencer for the 8-bit RISC CPU. Consumes the 3-bit opcode held by the instruction register and the accumulator zero flag, and steps through a fixed 8-phase instruction cycle, driving the memory, program counter, instruction register, accumulator and bus-driver control strobes. Sits between the instruction register and the datapath. A HLT instruction parks it in a halted state until reset.

## Interface
- No parameters; opcode and phase encodings come from the shared package.
- `clk` in 1 — system clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `opcode` in 3 — current instruction opcode from the instruction register.
- `zero` in 1 — accumulator-is-zero flag.
- `sel` out 1 — address mux select: 1 = PC, 0 = IR operand address.
- `rd` out 1 — memory read enable.
- `ld_ir` out 1 — instruction register load.
- `halt` out 1 — CPU halted indicator.
- `inc_pc` out 1 — program counter increment.
- `ld_ac` out 1 — accumulator load.
- `ld_pc` out 1 — program counter load (jump).
- `wr` out 1 — memory write enable.
- `data_e` out 1 — accumulator drives the data bus.

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = opcode is ADD, AND, XOR or LDA.
- State: 3-bit phase register P0..P7, plus a 1-bit `halted` flag.
- Not halted: phase advances P0→P1→…→P7→P0, one per clock, unconditionally.
- Outputs are combinational from the phase (registered), `halted`, `opcode` and `zero`. Any output not listed for a phase is 0.
  - P0 INST_ADDR: sel=1.
  - P1 INST_FETCH: sel=1, rd=1.
  - P2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - P3 IDLE: sel=1, rd=1, ld_ir=1.
  - P4 OP_ADDR: inc_pc = (opcode≠HLT); halt = (opcode==HLT).
  - P5 OP_FETCH: rd=ALUOP.
  - P6 ALU_OP: rd=ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - P7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Halt:
  - At the P4 clock edge with opcode==HLT, `halted` sets and the phase holds at P4.
  - While halted: halt=1, all other outputs 0, phase frozen.
  - Opcode changes are ignored while halted.
  - Only `rst` clears the halted state.
- SKZ with zero=0 and JMP produce no inc_pc in P6. No other opcode affects P6 inc_pc.

## Timing
- Reset (async assert, any phase, including while halted): phase=P0, halted=0.
  - Outputs during and after reset: sel=1, all others 0.
- First edge after reset release → P1.
- Every instruction takes exactly 8 cycles. HLT instead takes 5 cycles to reach the halted state.
- Output changes:
  - Phase-driven output changes are visible in the same cycle as the phase register update.
  - Opcode- and zero-dependent outputs follow input changes combinationally within a phase.
- `opcode` and `zero` need only be stable from P4 through P7. Their values in P0–P3 are don't-care.
- Phase wraps P7→P0 with no idle cycle.
- Reset mid-instruction abandons it. No strobe other than sel may be asserted in the reset cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams HLT..JMP;
  - phase encodings P_INST_ADDR..P_STORE;
  - an `is_aluop` function.
- Sub-module: `phase_counter` — 3-bit wrapping counter with hold input (driven by halted) and async reset. The remaining decode stays in `cpu_controller`.

## Test plan
- Reset pulse mid-P5 with opcode=ADD → phase=P0 immediately; outputs sel=1, all else 0; next edge reaches P1 with sel=1, rd=1.
- opcode=ADD over a full cycle:
  - rd=1 in P1,P2,P3,P5,P6,P7; ld_ir=1 in P2,P3; inc_pc=1 in P4 only;
  - ld_ac=1 in P7 only; wr, ld_pc and data_e never asserted.
- opcode=STO → data_e=1 in P6 and P7; wr=1 in P7 only; rd=0 in P5–P7; ld_ac never asserted.
- opcode=SKZ:
  - zero=1 → inc_pc=1 in both P4 and P6;
  - zero=0 → inc_pc=1 in P4 only.
- opcode=JMP → ld_pc=1 in P6 and P7; inc_pc=1 in P4; rd=0 in P5–P7.
- opcode=HLT:
  - halt=1 and inc_pc=0 in P4; phase stays P4 for 20 cycles with halt=1 and all else 0, even after opcode changes to ADD;
  - rst then returns phase to P0 with halt=0.
